// File: rtl/dmem_copy_engine_if.sv
// dmem_copy_engine_if
//   Shared data-memory bus between an initiator (CPU or copy engine) and
//   the arbiter/memory side.
//   bus_req  initiator -> arbiter : bus request
//   bus_gnt  arbiter -> initiator : bus grant
//   mem_we   initiator -> memory  : write enable
//   mem_a    initiator -> memory  : byte address
//   mem_wd   initiator -> memory  : write data
//   mem_rd   memory -> initiator  : read data (combinational from mem_a)
interface dmem_copy_engine_if;
  logic        bus_req;
  logic        bus_gnt;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport master (
    output bus_req, mem_we, mem_a, mem_wd,
    input  bus_gnt, mem_rd
  );

  modport slave (
    input  bus_req, mem_we, mem_a, mem_wd,
    output bus_gnt, mem_rd
  );
endinterface

// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine
//   Word-copy bus initiator. Copies len 32-bit words from src_addr to
//   dst_addr over the shared data-memory bus, one read cycle followed by
//   one write cycle per word. Either address may be held fixed so that a
//   memory-mapped peripheral can be sampled into RAM or a RAM buffer can
//   be streamed into a peripheral register.
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   start                launch request, honoured only while idle
//   src_addr, dst_addr   word-aligned first source / destination address
//   len                  word count (0 completes immediately)
//   src_inc, dst_inc     1: advance that address by 4 per word
//   busy                 engine is not idle
//   done                 one-cycle end-of-transfer pulse
//   err                  sticky misalignment flag, cleared by next start
//   words_left           words still to be written
//   bus                  master side of the data-memory bus
module dmem_copy_engine #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic             src_inc,
  input  logic             dst_inc,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_left,
  dmem_copy_engine_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [31:0]      src_reg, src_next;
  logic [31:0]      dst_reg, dst_next;
  logic [31:0]      data_reg, data_next;
  logic [LEN_W-1:0] count_reg, count_next;
  logic             src_inc_reg, src_inc_next;
  logic             dst_inc_reg, dst_inc_next;
  logic             err_reg, err_next;
  // mem_a / mem_wd must keep their last driven value outside READ/WRITE,
  // so the most recently presented values are remembered here.
  logic [31:0]      last_a_reg, last_a_next;
  logic [31:0]      last_wd_reg, last_wd_next;

  logic             bus_req_c;
  logic             mem_we_c;
  logic [31:0]      mem_a_c;
  logic [31:0]      mem_wd_c;
  logic             misaligned;

  assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      src_reg     <= '0;
      dst_reg     <= '0;
      data_reg    <= '0;
      count_reg   <= '0;
      src_inc_reg <= 1'b0;
      dst_inc_reg <= 1'b0;
      err_reg     <= 1'b0;
      last_a_reg  <= '0;
      last_wd_reg <= '0;
    end else begin
      state_reg   <= state_next;
      src_reg     <= src_next;
      dst_reg     <= dst_next;
      data_reg    <= data_next;
      count_reg   <= count_next;
      src_inc_reg <= src_inc_next;
      dst_inc_reg <= dst_inc_next;
      err_reg     <= err_next;
      last_a_reg  <= last_a_next;
      last_wd_reg <= last_wd_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    src_next     = src_reg;
    dst_next     = dst_reg;
    data_next    = data_reg;
    count_next   = count_reg;
    src_inc_next = src_inc_reg;
    dst_inc_next = dst_inc_reg;
    err_next     = err_reg;
    last_a_next  = last_a_reg;
    last_wd_next = last_wd_reg;
    bus_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    mem_a_c      = last_a_reg;
    mem_wd_c     = last_wd_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          src_next     = src_addr;
          dst_next     = dst_addr;
          src_inc_next = src_inc;
          dst_inc_next = dst_inc;
          err_next     = 1'b0;
          count_next   = '0;
          if (misaligned) begin
            // Rejected without touching the bus.
            err_next   = 1'b1;
            state_next = S_DONE;
          end else if (len == '0) begin
            state_next = S_DONE;
          end else begin
            count_next = len;
            state_next = S_REQ;
          end
        end
      end

      S_REQ: begin
        bus_req_c = 1'b1;
        if (bus.bus_gnt) begin
          state_next = S_READ;
        end
      end

      S_READ: begin
        bus_req_c   = 1'b1;
        mem_a_c     = src_reg;
        last_a_next = src_reg;
        if (bus.bus_gnt) begin
          data_next  = bus.mem_rd;
          state_next = S_WRITE;
        end else begin
          // Grant lost: nothing captured, the word is re-read later.
          state_next = S_REQ;
        end
      end

      S_WRITE: begin
        bus_req_c    = 1'b1;
        mem_a_c      = dst_reg;
        mem_wd_c     = data_reg;
        last_a_next  = dst_reg;
        last_wd_next = data_reg;
        // Gated combinationally so a write can never happen ungranted.
        mem_we_c     = bus.bus_gnt;
        if (bus.bus_gnt) begin
          count_next = count_reg - 1'b1;
          src_next   = src_reg + (src_inc_reg ? 32'd4 : 32'd0);
          dst_next   = dst_reg + (dst_inc_reg ? 32'd4 : 32'd0);
          if (count_reg == LEN_W'(1)) begin
            state_next = S_DONE;
          end else begin
            state_next = S_READ;
          end
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_reg != S_IDLE);
  assign done        = (state_reg == S_DONE);
  assign err         = err_reg;
  assign words_left  = count_reg;
  assign bus.bus_req = bus_req_c;
  assign bus.mem_we  = mem_we_c;
  assign bus.mem_a   = mem_a_c;
  assign bus.mem_wd  = mem_wd_c;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb_dmem_copy_engine
//   Directed bench: a RAM plus switch/LED/button peripherals answer the
//   engine's bus. Each transfer's expected write stream (address, data) is
//   derived from the copy rule dst+4k <- mem[src+4k] and checked on every
//   write cycle; literal cycle counts and memory contents pin the model.
module tb_dmem_copy_engine;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [7:0]  len = '0;
  logic        src_inc = 1'b0;
  logic        dst_inc = 1'b0;
  logic        busy, done, err;
  logic [7:0]  words_left;

  dmem_copy_engine_if bus();

  dmem_copy_engine #(.LEN_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .src_inc    (src_inc),
    .dst_inc    (dst_inc),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .words_left (words_left),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  // ---------------- memory system ----------------
  logic [31:0] ram [0:255];
  logic [31:0] sw, btn, leds;
  logic [31:0] rd;

  function automatic logic [31:0] peek(input logic [31:0] a);
    if (a == 32'hC000_0000)      return sw;
    else if (a == 32'hC000_0004) return leds;
    else if (a == 32'hC000_0008) return btn;
    else if (a < 32'h400)        return ram[a[9:2]];
    else                         return 32'h0;
  endfunction

  always_comb begin
    rd = 32'h0;
    if (bus.mem_a == 32'hC000_0000)      rd = sw;
    else if (bus.mem_a == 32'hC000_0004) rd = leds;
    else if (bus.mem_a == 32'hC000_0008) rd = btn;
    else if (bus.mem_a < 32'h400)        rd = ram[bus.mem_a[9:2]];
  end
  assign bus.mem_rd = rd;

  always @(posedge clk) begin
    if (bus.mem_we) begin
      if (bus.mem_a == 32'hC000_0004) leds <= bus.mem_wd;
      else if (bus.mem_a < 32'h400)   ram[bus.mem_a[9:2]] <= bus.mem_wd;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          wr_cnt;
  logic        saw_req;
  logic [31:0] max_rd_a;

  // Compare process: every write on the bus must be the next one the
  // copy rule predicts, and must only happen while granted.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.mem_we) begin
        wr_t w;
        wr_cnt++;
        chk("we_while_granted", bus.bus_gnt, 1'b1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, required no write",
                   bus.mem_a, bus.mem_wd);
        end else begin
          w = exp_q.pop_front();
          chk("write_addr", bus.mem_a, w.a);
          chk("write_data", bus.mem_wd, w.d);
        end
      end
      if (bus.bus_req) saw_req = 1'b1;
      if (bus.bus_req && bus.bus_gnt && !bus.mem_we && bus.mem_a > max_rd_a)
        max_rd_a = bus.mem_a;
      if (done) chk("done_without_req", bus.bus_req, 1'b0);
      if (bus.bus_req) chk("req_implies_busy", busy, 1'b1);
    end
  end

  // Runs one transfer. Grant is low in cycles stall_lo..stall_hi; if
  // abort_cyc > 0 reset is asserted inside that cycle instead of finishing.
  task automatic run(input logic [31:0] s, input logic [31:0] d, input int n,
                     input bit si, input bit di, input int stall_lo, input int stall_hi,
                     input int abort_cyc, output int done_cyc);
    bit aligned;
    aligned = (s[1:0] == 2'b00) && (d[1:0] == 2'b00);
    exp_q.delete();
    if (aligned) begin
      for (int k = 0; k < n; k++) begin
        wr_t w;
        w.a = d + (di ? 32'(4 * k) : 32'd0);
        w.d = peek(s + (si ? 32'(4 * k) : 32'd0));
        exp_q.push_back(w);
      end
    end
    wr_cnt   = 0;
    saw_req  = 1'b0;
    max_rd_a = 32'h0;
    done_cyc = -1;

    @(negedge clk);
    src_addr = s; dst_addr = d; len = 8'(n);
    src_inc = si; dst_inc = di; start = 1'b1;
    bus.bus_gnt = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    for (int c = 1; c <= 300; c++) begin
      bus.bus_gnt = (c >= stall_lo && c <= stall_hi) ? 1'b0 : 1'b1;
      if (c == 1) chk("words_left_start", words_left, (aligned && n > 0) ? 32'(n) : 32'd0);
      if (c == abort_cyc) begin
        reset_n = 1'b0;
        #1;
        chk("abort_mem_we", bus.mem_we, 1'b0);
        chk("abort_bus_req", bus.bus_req, 1'b0);
        chk("abort_busy", busy, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        bus.bus_gnt = 1'b1;
        return;
      end
      @(negedge clk);
      if (done) begin
        done_cyc = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.bus_gnt = 1'b1;

    if (done_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within 300 cycles, required one");
    end else begin
      chk("words_left_done", words_left, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("done_one_cycle", done, 1'b0);
      chk("busy_after_done", busy, 1'b0);
      chk("write_count", wr_cnt, aligned ? 32'(n) : 32'd0);
      chk("writes_pending", exp_q.size(), 32'd0);
    end
    $display("xfer src=0x%08h dst=0x%08h len=%0d inc=%0d%0d done_cycle=%0d writes=%0d",
             s, d, n, si, di, done_cyc, wr_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    for (int i = 0; i < 256; i++) ram[i] = 32'hDEAD_0000 | 32'(i);
    ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33; ram[3] = 32'h44;
    ram[4] = 32'hA1; ram[5] = 32'hB2; ram[8] = 32'h3FF;
    sw = 32'h2A5; btn = 32'h1; leds = 32'h0;
    bus.bus_gnt = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_bus_req", bus.bus_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_words_left", words_left, 32'd0);
    chk("rst_mem_a", bus.mem_a, 32'd0);
    chk("rst_mem_wd", bus.mem_wd, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // RAM -> RAM, continuous grant
    run(32'h0, 32'h40, 4, 1, 1, -1, -1, 0, dc);
    chk("ram_copy_done_cycle", dc, 32'd10);
    chk("ram16", ram[16], 32'h11);
    chk("ram17", ram[17], 32'h22);
    chk("ram18", ram[18], 32'h33);
    chk("ram19", ram[19], 32'h44);

    // Switch sampling, fixed source
    run(32'hC000_0000, 32'h80, 3, 0, 1, -1, -1, 0, dc);
    chk("sample_done_cycle", dc, 32'd8);
    chk("ram32", ram[32], 32'h2A5);
    chk("ram33", ram[33], 32'h2A5);
    chk("ram34", ram[34], 32'h2A5);
    chk("sample_read_bound", max_rd_a > 32'hC000_0000, 1'b0);

    // RAM -> LEDs, fixed destination
    run(32'h20, 32'hC000_0004, 1, 1, 0, -1, -1, 0, dc);
    chk("led_done_cycle", dc, 32'd4);
    chk("leds", leds, 32'h3FF);

    // Grant dropped for 3 cycles during word 0 write
    run(32'h10, 32'h100, 2, 1, 1, 3, 5, 0, dc);
    chk("stall_done_cycle", dc, 32'd9);
    chk("ram64", ram[64], 32'hA1);
    chk("ram65", ram[65], 32'hB2);

    // Misaligned destination
    run(32'h0, 32'h42, 2, 1, 1, -1, -1, 0, dc);
    chk("err_done_cycle", dc, 32'd1);
    chk("err_set", err, 1'b1);
    chk("err_no_req", saw_req, 1'b0);

    // Next valid start clears err
    run(32'h0, 32'h200, 1, 1, 1, -1, -1, 0, dc);
    chk("clear_done_cycle", dc, 32'd4);
    chk("err_cleared", err, 1'b0);
    chk("ram128", ram[128], 32'h11);

    // Zero length
    run(32'h0, 32'h300, 0, 1, 1, -1, -1, 0, dc);
    chk("zero_done_cycle", dc, 32'd1);
    chk("zero_err", err, 1'b0);
    chk("zero_no_req", saw_req, 1'b0);

    // Reset during the second word's write
    run(32'h0, 32'h380, 2, 1, 1, -1, -1, 5, dc);
    exp_q.delete();
    chk("abort_word0", ram[224], 32'h11);
    chk("abort_word1_kept", ram[225], 32'hDEAD_00E1);
    chk("abort_words_left", words_left, 32'd0);
    chk("abort_mem_a", bus.mem_a, 32'd0);
    chk("abort_mem_wd", bus.mem_wd, 32'd0);
    $display("xfer aborted by reset in cycle 5");

    // Restart after reset
    run(32'h0, 32'h380, 2, 1, 1, -1, -1, 0, dc);
    chk("restart_done_cycle", dc, 32'd6);
    chk("restart_word1", ram[225], 32'h22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
